// File: rtl/keypad_emulator.sv
// keypad_emulator
//   4x4 matrix-keypad model that sits opposite a row-scanning controller.
//   A press command (key code + hold time) is accepted over a valid/ready
//   port.  The emulated contact then bounces in, stays closed for the hold
//   time, bounces out, and is forced open for a gap before the next command.
//   While the contact is closed, the key's column is pulled low whenever the
//   scanner drives the key's row low.
//
// Ports
//   clk        in   system clock
//   reset      in   asynchronous, active-low reset
//   cmd_valid  in   press request valid
//   cmd_key    in   [3:0] hex key code to press
//   cmd_hold   in   [15:0] clean-closed hold time in cycles (0 acts as 1)
//   cmd_ready  out  high only while idle
//   rows       in   [3:0] row drive, active-low
//   cols       out  [3:0] column sense, active-low (0 = pulled by closed key)
//   key_down   out  current contact state (1 = closed)
//   busy       out  high whenever not idle
//   dbg_state  out  [2:0] current FSM state encoding
//
// Command handshake: a command transfers on a rising clk edge where
// cmd_valid && cmd_ready are both high. cmd_ready is high only in IDLE;
// cmd_valid seen in any other state is ignored, nothing is queued, so the
// requester must hold cmd_valid and its payload until the transfer edge.

module keypad_emulator #(
  parameter int BOUNCE_CYCLES = 8,
  parameter int BOUNCE_PERIOD = 2,
  parameter int GAP_CYCLES    = 4
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        cmd_valid,
  input  logic [3:0]  cmd_key,
  input  logic [15:0] cmd_hold,
  output logic        cmd_ready,
  input  logic [3:0]  rows,
  output logic [3:0]  cols,
  output logic        key_down,
  output logic        busy,
  output logic [2:0]  dbg_state
);

  typedef enum logic [2:0] {
    S_IDLE       = 3'd0,
    S_BOUNCE_IN  = 3'd1,
    S_HOLD       = 3'd2,
    S_BOUNCE_OUT = 3'd3,
    S_GAP        = 3'd4
  } state_t;

  // Counters are loaded with (length - 1) so that the state exits on the
  // edge where the counter already reads zero.
  localparam bit          HAS_BOUNCE = (BOUNCE_CYCLES > 0);
  localparam bit          HAS_GAP    = (GAP_CYCLES > 0);
  localparam logic [15:0] B_LOAD = HAS_BOUNCE ? 16'(BOUNCE_CYCLES - 1) : 16'd0;
  localparam logic [15:0] P_LOAD = (BOUNCE_PERIOD > 1) ? 16'(BOUNCE_PERIOD - 1) : 16'd0;
  localparam logic [15:0] G_LOAD = HAS_GAP ? 16'(GAP_CYCLES - 1) : 16'd0;

  state_t      state, state_n;
  logic [15:0] cnt, cnt_n;
  logic [15:0] pcnt, pcnt_n;
  logic        contact, contact_n;
  logic [3:0]  key_r, key_n;
  logic [15:0] hold_r, hold_n;
  logic [15:0] hold_load_cmd, hold_load_r;
  logic [1:0]  krow, kcol;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state   <= S_IDLE;
      cnt     <= 16'd0;
      pcnt    <= 16'd0;
      contact <= 1'b0;
      key_r   <= 4'd0;
      hold_r  <= 16'd0;
    end else begin
      state   <= state_n;
      cnt     <= cnt_n;
      pcnt    <= pcnt_n;
      contact <= contact_n;
      key_r   <= key_n;
      hold_r  <= hold_n;
    end
  end

  // A hold of 0 behaves like 1, so the load value saturates at 0.
  assign hold_load_cmd = (cmd_hold == 16'd0) ? 16'd0 : cmd_hold - 16'd1;
  assign hold_load_r   = (hold_r == 16'd0) ? 16'd0 : hold_r - 16'd1;

  always_comb begin
    state_n   = state;
    cnt_n     = cnt;
    pcnt_n    = pcnt;
    contact_n = contact;
    key_n     = key_r;
    hold_n    = hold_r;
    case (state)
      S_IDLE: begin
        contact_n = 1'b0;
        if (cmd_valid) begin
          key_n     = cmd_key;
          hold_n    = cmd_hold;
          contact_n = 1'b1;
          if (HAS_BOUNCE) begin
            state_n = S_BOUNCE_IN;
            cnt_n   = B_LOAD;
            pcnt_n  = P_LOAD;
          end else begin
            state_n = S_HOLD;
            cnt_n   = hold_load_cmd;
          end
        end
      end
      S_BOUNCE_IN, S_BOUNCE_OUT: begin
        if (cnt == 16'd0) begin
          if (state == S_BOUNCE_IN) begin
            state_n   = S_HOLD;
            contact_n = 1'b1;
            cnt_n     = hold_load_r;
          end else begin
            contact_n = 1'b0;
            state_n   = HAS_GAP ? S_GAP : S_IDLE;
            cnt_n     = G_LOAD;
          end
        end else begin
          cnt_n = cnt - 16'd1;
          // Toggle at each period boundary; a trailing partial period is
          // simply cut off when cnt reaches zero.
          if (pcnt == 16'd0) begin
            contact_n = ~contact;
            pcnt_n    = P_LOAD;
          end else begin
            pcnt_n = pcnt - 16'd1;
          end
        end
      end
      S_HOLD: begin
        if (cnt == 16'd0) begin
          contact_n = 1'b0;
          if (HAS_BOUNCE) begin
            state_n = S_BOUNCE_OUT;
            cnt_n   = B_LOAD;
            pcnt_n  = P_LOAD;
          end else begin
            state_n = HAS_GAP ? S_GAP : S_IDLE;
            cnt_n   = G_LOAD;
          end
        end else begin
          cnt_n = cnt - 16'd1;
        end
      end
      S_GAP: begin
        contact_n = 1'b0;
        if (cnt == 16'd0) state_n = S_IDLE;
        else              cnt_n   = cnt - 16'd1;
      end
      default: begin
        state_n   = S_IDLE;
        contact_n = 1'b0;
      end
    endcase
  end

  // Key code -> (row, column) of the physical matrix.
  always_comb begin
    krow = 2'd0;
    kcol = 2'd0;
    case (key_r)
      4'h1: begin krow = 2'd0; kcol = 2'd0; end
      4'h2: begin krow = 2'd0; kcol = 2'd1; end
      4'h3: begin krow = 2'd0; kcol = 2'd2; end
      4'hA: begin krow = 2'd0; kcol = 2'd3; end
      4'h4: begin krow = 2'd1; kcol = 2'd0; end
      4'h5: begin krow = 2'd1; kcol = 2'd1; end
      4'h6: begin krow = 2'd1; kcol = 2'd2; end
      4'hB: begin krow = 2'd1; kcol = 2'd3; end
      4'h7: begin krow = 2'd2; kcol = 2'd0; end
      4'h8: begin krow = 2'd2; kcol = 2'd1; end
      4'h9: begin krow = 2'd2; kcol = 2'd2; end
      4'hC: begin krow = 2'd2; kcol = 2'd3; end
      4'hE: begin krow = 2'd3; kcol = 2'd0; end
      4'h0: begin krow = 2'd3; kcol = 2'd1; end
      4'hF: begin krow = 2'd3; kcol = 2'd2; end
      default: begin krow = 2'd3; kcol = 2'd3; end  // 4'hD
    endcase
  end

  // Unregistered rows -> cols path: the scanner sees the column respond in
  // the same cycle it drives a row. Because contact is cleared by the async
  // reset, reset also releases the column without waiting for a clock.
  always_comb begin
    cols = 4'b1111;
    if (contact && !rows[krow]) cols[kcol] = 1'b0;
  end

  assign key_down  = contact;
  assign cmd_ready = (state == S_IDLE);
  assign busy      = (state != S_IDLE);
  assign dbg_state = state;

endmodule

// File: tb/tb_keypad_emulator.sv
// tb_keypad_emulator
//   Directed bench for keypad_emulator. Two instances share clk/reset:
//   u_dut_a uses the default bounce/gap parameters, u_dut_b has bounce
//   disabled for key-map and short-hold vectors. Inputs are driven and
//   outputs sampled at the falling clock edge (plus small #1 offsets for
//   same-cycle rows -> cols checks).

module tb_keypad_emulator;

  logic        clk = 1'b0;
  logic        reset;

  logic        cmd_valid_a, cmd_valid_b;
  logic [3:0]  cmd_key_a, cmd_key_b;
  logic [15:0] cmd_hold_a, cmd_hold_b;
  logic        ready_a, ready_b;
  logic [3:0]  rows_a, rows_b;
  logic [3:0]  cols_a, cols_b;
  logic        key_down_a, key_down_b;
  logic        busy_a, busy_b;
  logic [2:0]  state_a, state_b;

  int n_checks = 0;
  int n_errors = 0;

  // Key codes laid out by [row][column] of the physical matrix.
  logic [3:0] kmap [4][4] = '{'{4'h1, 4'h2, 4'h3, 4'hA},
                              '{4'h4, 4'h5, 4'h6, 4'hB},
                              '{4'h7, 4'h8, 4'h9, 4'hC},
                              '{4'hE, 4'h0, 4'hF, 4'hD}};

  keypad_emulator u_dut_a (
    .clk(clk), .reset(reset),
    .cmd_valid(cmd_valid_a), .cmd_key(cmd_key_a), .cmd_hold(cmd_hold_a),
    .cmd_ready(ready_a), .rows(rows_a), .cols(cols_a),
    .key_down(key_down_a), .busy(busy_a), .dbg_state(state_a)
  );

  keypad_emulator #(.BOUNCE_CYCLES(0), .BOUNCE_PERIOD(2), .GAP_CYCLES(4)) u_dut_b (
    .clk(clk), .reset(reset),
    .cmd_valid(cmd_valid_b), .cmd_key(cmd_key_b), .cmd_hold(cmd_hold_b),
    .cmd_ready(ready_b), .rows(rows_b), .cols(cols_b),
    .key_down(key_down_b), .busy(busy_b), .dbg_state(state_b)
  );

  // ---------------- clock ----------------
  always #5 clk = ~clk;

  // ---------------- checking ----------------
  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  // ---------------- drivers (called at a falling edge) ----------------
  task automatic wait_idle_a();
    int i = 0;
    while (!ready_a && i < 300) begin
      @(negedge clk);
      i++;
    end
    if (!ready_a) check("wait_idle_a timeout", 32'(ready_a), 32'd1);
  endtask

  task automatic wait_idle_b();
    int i = 0;
    while (!ready_b && i < 300) begin
      @(negedge clk);
      i++;
    end
    if (!ready_b) check("wait_idle_b timeout", 32'(ready_b), 32'd1);
  endtask

  // Returns at the falling edge inside cycle 1 (first cycle after E0).
  task automatic press_a(input logic [3:0] k, input logic [15:0] h);
    wait_idle_a();
    cmd_valid_a = 1'b1;
    cmd_key_a   = k;
    cmd_hold_a  = h;
    @(posedge clk);
    @(negedge clk);
    cmd_valid_a = 1'b0;
  endtask

  task automatic press_b(input logic [3:0] k, input logic [15:0] h);
    wait_idle_b();
    cmd_valid_b = 1'b1;
    cmd_key_b   = k;
    cmd_hold_b  = h;
    @(posedge clk);
    @(negedge clk);
    cmd_valid_b = 1'b0;
  endtask

  task automatic skip(input int n);
    for (int i = 0; i < n; i++) @(negedge clk);
  endtask

  // ---------------- stimulus ----------------
  initial begin
    logic [0:7] press_cols;
    logic [0:7] rel_cols;
    logic       exp_bit;
    logic [3:0] one;
    logic [3:0] exp_cols;

    // Column level seen by the scanner during the press / release bounce.
    press_cols = 8'b00110011;
    rel_cols   = 8'b11001100;

    reset       = 1'b0;
    cmd_valid_a = 1'b0; cmd_key_a = 4'h0; cmd_hold_a = 16'd0; rows_a = 4'b1111;
    cmd_valid_b = 1'b0; cmd_key_b = 4'h0; cmd_hold_b = 16'd0; rows_b = 4'b1111;

    // Reset state with every row pattern.
    #1;
    for (int r = 0; r < 16; r++) begin
      rows_a = 4'(r);
      rows_b = 4'(r);
      #1;
      check("rst cols_a", 32'(cols_a), 32'hF);
      check("rst cols_b", 32'(cols_b), 32'hF);
      check("rst ready", 32'(ready_a), 32'd1);
      check("rst busy", 32'(busy_a), 32'd0);
      check("rst key_down", 32'(key_down_a), 32'd0);
    end
    check("rst state", 32'(state_a), 32'd0);
    @(negedge clk);
    reset = 1'b1;
    rows_b = 4'b1111;
    @(negedge clk);

    // Key 5, hold 20, default bounce: full column timeline.
    rows_a = 4'b1101;
    press_a(4'h5, 16'd20);
    for (int n = 1; n <= 41; n++) begin
      if (n <= 8)       exp_bit = press_cols[n-1];
      else if (n <= 28) exp_bit = 1'b0;
      else if (n <= 36) exp_bit = rel_cols[n-29];
      else              exp_bit = 1'b1;
      if (n <= 40) begin
        check($sformatf("k5 cols[1] cyc%0d", n), 32'(cols_a[1]), 32'(exp_bit));
        check($sformatf("k5 other cols cyc%0d", n), 32'({cols_a[3:2], cols_a[0]}), 32'h7);
      end
      if (n == 40) check("k5 ready cyc40", 32'(ready_a), 32'd0);
      if (n == 41) check("k5 ready cyc41", 32'(ready_a), 32'd1);
      if (n < 41) @(negedge clk);
    end

    // Row mismatch and multi-row drive during HOLD.
    press_a(4'h5, 16'd20);
    skip(11);                       // cycle 12, inside HOLD
    rows_a = 4'b1110; #1;
    check("mismatch row0", 32'(cols_a), 32'hF);
    rows_a = 4'b1101; #1;
    check("match row1", 32'(cols_a), 32'hD);
    rows_a = 4'b0101; #1;
    check("multi rows", 32'(cols_a), 32'hD);
    rows_a = 4'b1111; #1;
    check("no rows", 32'(cols_a), 32'hF);
    rows_a = 4'b1101;
    @(negedge clk);

    // Full key map on the bounce-free instance.
    for (int r = 0; r < 4; r++) begin
      for (int c = 0; c < 4; c++) begin
        press_b(kmap[r][c], 16'd8);
        check($sformatf("map key_down %0h", kmap[r][c]), 32'(key_down_b), 32'd1);
        for (int s = 0; s < 4; s++) begin
          one = 4'b0001 << s;
          rows_b = ~one;
          #1;
          if (s == r) begin
            one = 4'b0001 << c;
            exp_cols = ~one;
          end else begin
            exp_cols = 4'b1111;
          end
          check($sformatf("map key %0h row%0d", kmap[r][c], s), 32'(cols_b), 32'(exp_cols));
        end
        rows_b = 4'b1111;
        @(negedge clk);
      end
    end

    // Command while busy is ignored; hold 0 acts as one cycle.
    press_b(4'h5, 16'd3);           // HOLD 1..3, GAP 4..7, IDLE 8
    check("ign busy cyc1", 32'(busy_b), 32'd1);
    @(negedge clk);                 // cycle 2
    cmd_valid_b = 1'b1; cmd_key_b = 4'hA; cmd_hold_b = 16'd10;
    skip(5);                        // cycle 7
    cmd_valid_b = 1'b0;
    check("ign ready cyc7", 32'(ready_b), 32'd0);
    @(negedge clk);                 // cycle 8
    check("ign ready cyc8", 32'(ready_b), 32'd1);
    check("ign busy cyc8", 32'(busy_b), 32'd0);
    check("ign key_down cyc8", 32'(key_down_b), 32'd0);
    @(negedge clk);
    check("ign no queue", 32'(busy_b), 32'd0);

    rows_b = 4'b0111;
    press_b(4'h0, 16'd0);
    check("hold0 key_down cyc1", 32'(key_down_b), 32'd1);
    check("hold0 cols cyc1", 32'(cols_b), 32'hD);
    @(negedge clk);
    check("hold0 key_down cyc2", 32'(key_down_b), 32'd0);
    check("hold0 cols cyc2", 32'(cols_b), 32'hF);
    check("hold0 busy cyc2", 32'(busy_b), 32'd1);
    rows_b = 4'b1111;

    // Asynchronous reset in the middle of HOLD.
    @(negedge clk);
    rows_a = 4'b0111;
    press_a(4'h0, 16'd20);
    skip(11);                       // cycle 12, inside HOLD
    check("areset pre cols", 32'(cols_a), 32'hD);
    #2 reset = 1'b0;
    #1;
    check("areset cols", 32'(cols_a), 32'hF);
    check("areset key_down", 32'(key_down_a), 32'd0);
    check("areset busy", 32'(busy_a), 32'd0);
    check("areset ready", 32'(ready_a), 32'd1);
    @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    check("post reset ready", 32'(ready_a), 32'd1);
    check("post reset busy", 32'(busy_a), 32'd0);
    check("post reset cols", 32'(cols_a), 32'hF);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/keypad_emulator.md
# keypad_emulator

Synthesizable 4x4 matrix-keypad model that answers a row-scanning keypad controller: it samples the scanner's row drive and pulls the matching column line when an emulated key is closed. Key presses are issued through a valid/ready command port with a programmable hold time, and every press and release is wrapped in deterministic contact bounce. It sits opposite `digit_controller` on the rows/cols wires and lets benches and hardware-in-loop rigs replay key sequences.

## Interface

Parameters:

- `BOUNCE_CYCLES`, default 8: length of each bounce window (press and release), in clk cycles. 0 disables bounce.
- `BOUNCE_PERIOD`, default 2: cycles per contact level while bouncing; must be ≥1.
- `GAP_CYCLES`, default 4: forced released time after each press before the next command is accepted.

Ports:

- `clk`  in  1  system clock.
- `reset`  in  1  asynchronous, active-low reset.
- `cmd_valid`  in  1  press request valid.
- `cmd_key`  in  4  hex key code to press.
- `cmd_hold`  in  16  clean-closed hold time in cycles; 0 is treated as 1.
- `cmd_ready`  out  1  high only in IDLE.
- `rows`  in  4  row drive from the scanner, active-low: a row is driven when its bit is 0.
- `cols`  out  4  column sense, active-low: 1 = released/pulled-up, 0 = pulled by a closed key.
- `key_down`  out  1  current contact state (1 = closed).
- `busy`  out  1  high in every state except IDLE.

## Operation

- Key map, row index then column index 0..3: row0 = 1,2,3,A; row1 = 4,5,6,B; row2 = 7,8,9,C; row3 = E,0,F,D.
- `cmd_key` is latched into `key_r` on acceptance. The latched key gives `krow` and `kcol`.
- `cols` is combinational from the registered contact and `rows`: `cols[kcol] = 0` iff `contact && rows[krow] == 0`. All other bits are 1.
- With several rows driven low, the key column is still pulled if `krow` is among them. With `rows = 4'b1111`, `cols = 4'b1111`.
- The FSM uses a 16-bit down-counter `cnt` and a bounce phase counter. States:
  - **IDLE**: `contact = 0`, `cmd_ready = 1`. Handshake `cmd_valid && cmd_ready` latches key and hold. Next state is BOUNCE_IN, or HOLD if `BOUNCE_CYCLES == 0`.
  - **BOUNCE_IN**: `BOUNCE_CYCLES` cycles. Contact starts at 1 and toggles every `BOUNCE_PERIOD` cycles. Then HOLD.
  - **HOLD**: `max(cmd_hold, 1)` cycles with `contact = 1`. Then BOUNCE_OUT, or GAP if `BOUNCE_CYCLES == 0`.
  - **BOUNCE_OUT**: `BOUNCE_CYCLES` cycles. Contact starts at 0 and toggles every `BOUNCE_PERIOD` cycles. Then GAP.
  - **GAP**: `GAP_CYCLES` cycles with `contact = 0`. Then IDLE. If `GAP_CYCLES == 0`, go straight to IDLE.
- `cmd_valid` outside IDLE is ignored. No queueing; the command must be held until accepted.
- `key_down` equals `contact`.

## Timing

- Reset (async, `reset == 0`) forces IDLE, `contact = 0`, `key_r = 0`, and counters to 0. Outputs during reset: `cols = 4'b1111`, `key_down = 0`, `busy = 0`, `cmd_ready = 1`.
- Reset mid-press releases the column immediately, without waiting for a clock edge.
- Acceptance edge = E0. Cycle n is the cycle after edge En-1.
- BOUNCE_IN occupies cycles 1..B, HOLD cycles B+1..B+H, BOUNCE_OUT the next B cycles, then GAP for G cycles. Here B = `BOUNCE_CYCLES`, H = `max(cmd_hold, 1)`, G = `GAP_CYCLES`.
- `cmd_ready` returns high in cycle 2B+H+G+1. The earliest next acceptance is at that cycle's closing edge.
- Bounce pattern with defaults: press = 1,1,0,0,1,1,0,0; release = 0,0,1,1,0,0,1,1.
- If `BOUNCE_CYCLES` is not a multiple of `BOUNCE_PERIOD`, the final partial period is truncated.
- `cols` responds to a `rows` change in the same cycle, with no register in that path.
- `cmd_hold = 16'hFFFF` holds for 65535 cycles with no counter wrap.

## Test plan

- **Reset state:** hold `reset = 0`, sweep `rows` over all 16 values. Required: `cols = 4'b1111`, `cmd_ready = 1`, `busy = 0`, `key_down = 0`.
- **Key 5, hold 20, defaults:**
  - Accept at E0 with `rows = 4'b1101`.
  - Required `cols[1]`: cycles 1..8 = 0,0,1,1,0,0,1,1; cycles 9..28 = 0; cycles 29..36 = 1,1,0,0,1,1,0,0; cycles 37..40 = 1.
  - Required: `cmd_ready = 1` in cycle 41.
- **Row mismatch:** same press of key 5, drive `rows = 4'b1110` during HOLD. Required: `cols = 4'b1111`. Switching to `rows = 4'b1101` in the same cycle gives `cols = 4'b1101`.
- **Full key map:** with `BOUNCE_CYCLES = 0`, press all 16 codes, cycling one-hot-low rows as a scanner would. Required: exactly the mapped (row, col) pair pulls low, e.g. key D pulls `cols = 4'b0111` only while `rows = 4'b0111`.
- **Ignored command and hold 0:** `cmd_valid` with key A while busy is not accepted. A later accepted command with `cmd_hold = 0` holds exactly 1 cycle (with `BOUNCE_CYCLES = 0`, `key_down` is high for one cycle).
- **Async reset mid-HOLD:** drop `reset` between clock edges while key 0 is held. Required: `cols = 4'b1111` before the next edge. After release: IDLE, `cmd_ready = 1`.
